// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: operand word type and forwarding-select
// encodings, used by the forward-A/B muxes and the hazard unit.
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int FWD_SEL_W = 3;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  // Forwarding select encodings; anything with bit 2 set is illegal.
  localparam fwd_sel_t FWD_NONE = 3'd0;  // register-file operand
  localparam fwd_sel_t FWD_S1   = 3'd1;  // nearest stage result
  localparam fwd_sel_t FWD_S2   = 3'd2;  // next stage result
  localparam fwd_sel_t FWD_S3   = 3'd3;  // furthest stage result

  // Single definition of "illegal select" shared by muxes and hazard unit.
  function automatic logic fwd_sel_illegal(input fwd_sel_t sel);
    return sel[2];
  endfunction

endpackage

// File: rtl/fwd_mux_fa6.sv
// Forward-A operand mux for pipeline stage 6. Selects the register-file
// operand or one of three forwarded results, with a registered copy and a
// sticky illegal-select flag. Illegal selects fall back to the
// non-forwarded operand so a hazard-unit glitch never injects stale data.
module fwd_mux_fa6
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SEL_W = FWD_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_err,
  output logic             sel_err_q
);

  logic [WIDTH-1:0] y_d;
  logic             sel_err_d;

  // Combinational operand select and illegal-select detect.
  always_comb begin
    // NOTE: assign every output a default first so no path through the
    // case can leave it unassigned and infer a latch.
    y       = a0;
    sel_err = fwd_sel_illegal(s);
    case (s)
      FWD_NONE: y = a0;
      FWD_S1:   y = a1;
      FWD_S2:   y = a2;
      FWD_S3:   y = a3;
      default:  y = a0;
    endcase
  end

  // Next-state for the registered copy and the sticky error flag.
  always_comb begin
    y_d       = y;
    sel_err_d = sel_err_q | sel_err;
  end

  // State registers with synchronous reset taking priority over sampling.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge
    // values, independent of statement order.
    if (rst) begin
      y_q       <= '0;
      sel_err_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      sel_err_q <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_fwd_mux_fa6.sv
// Directed self-checking bench for fwd_mux_fa6.
module tb_fwd_mux_fa6;

  logic        clk;
  logic        rst;
  logic [31:0] a0, a1, a2, a3;
  logic [2:0]  s;
  logic [31:0] y, y_q;
  logic        sel_err, sel_err_q;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fwd_mux_fa6 dut (
    .clk       (clk),
    .rst       (rst),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .s         (s),
    .y         (y),
    .y_q       (y_q),
    .sel_err   (sel_err),
    .sel_err_q (sel_err_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a0 = 0; a1 = 0; a2 = 0; a3 = 0; s = 3'd5; rst = 1'b1;
    #1;
    total_cnt++;
    if (y !== 32'd0) $display("FAIL reset_y: got %h want %h", y, 32'd0);
    else pass_cnt++;
    total_cnt++;
    if (sel_err !== 1'b1) $display("FAIL reset_sel_err: got %b want 1", sel_err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (y_q !== 32'd0) $display("FAIL reset_y_q: got %h want %h", y_q, 32'd0);
    else pass_cnt++;
    total_cnt++;
    if (sel_err_q !== 1'b0) $display("FAIL reset_sel_err_q: got %b want 0", sel_err_q);
    else pass_cnt++;
  endtask

  task automatic test_sticky();
    rst = 1'b0; a0 = 1; a1 = 2; a2 = 3; a3 = 4; s = 3'd4;
    #1;
    total_cnt++;
    if (y !== 32'd1) $display("FAIL s4_y: got %h want %h", y, 32'd1);
    else pass_cnt++;
    total_cnt++;
    if (sel_err !== 1'b1) $display("FAIL s4_sel_err: got %b want 1", sel_err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (y_q !== 32'd1) $display("FAIL s4_y_q: got %h want %h", y_q, 32'd1);
    else pass_cnt++;
    total_cnt++;
    if (sel_err_q !== 1'b1) $display("FAIL s4_sel_err_q: got %b want 1", sel_err_q);
    else pass_cnt++;
    s = 3'd1;
    tick();
    tick();
    total_cnt++;
    if (sel_err_q !== 1'b1) $display("FAIL sticky_hold: got %b want 1", sel_err_q);
    else pass_cnt++;
  endtask

  task automatic test_sweep();
    logic [2:0]  sel_tab [4] = '{3'd1, 3'd2, 3'd0, 3'd3};
    logic [31:0] exp_tab [4] = '{32'd2, 32'd3, 32'd1, 32'd4};
    for (int i = 0; i < 4; i++) begin
      s = sel_tab[i];
      #1;
      total_cnt++;
      if (y !== exp_tab[i]) $display("FAIL sweep_y[%0d]: got %h want %h", i, y, exp_tab[i]);
      else pass_cnt++;
      total_cnt++;
      if (sel_err !== 1'b0) $display("FAIL sweep_sel_err[%0d]: got %b want 0", i, sel_err);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (y_q !== exp_tab[i]) $display("FAIL sweep_y_q[%0d]: got %h want %h", i, y_q, exp_tab[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sel_err_q !== 1'b1) $display("FAIL sweep_sticky: got %b want 1", sel_err_q);
    else pass_cnt++;
  endtask

  task automatic test_illegal_high();
    logic [2:0] sel_tab [2] = '{3'd7, 3'd6};
    for (int i = 0; i < 2; i++) begin
      s = sel_tab[i];
      #1;
      total_cnt++;
      if (y !== 32'd1) $display("FAIL illegal_y[s=%0d]: got %h want %h", sel_tab[i], y, 32'd1);
      else pass_cnt++;
      total_cnt++;
      if (sel_err !== 1'b1) $display("FAIL illegal_sel_err[s=%0d]: got %b want 1", sel_tab[i], sel_err);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold_change();
    s = 3'd2; a2 = 32'd3;
    tick();
    a2 = 32'hFFFF_FFFF;
    #1;
    total_cnt++;
    if (y !== 32'hFFFF_FFFF) $display("FAIL hold_y: got %h want %h", y, 32'hFFFF_FFFF);
    else pass_cnt++;
    total_cnt++;
    if (y_q !== 32'd3) $display("FAIL hold_y_q_old: got %h want %h", y_q, 32'd3);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (y_q !== 32'hFFFF_FFFF) $display("FAIL hold_y_q_new: got %h want %h", y_q, 32'hFFFF_FFFF);
    else pass_cnt++;
    a0 = 32'hDEAD_0000; a1 = 32'h1234_5678; a3 = 32'h0BAD_F00D;
    #1;
    total_cnt++;
    if (y !== 32'hFFFF_FFFF) $display("FAIL unselected_y: got %h want %h", y, 32'hFFFF_FFFF);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    a0 = 1; a1 = 2; a2 = 3; a3 = 4; s = 3'd3;
    tick();
    total_cnt++;
    if (y_q !== 32'd4) $display("FAIL mid_pre_y_q: got %h want %h", y_q, 32'd4);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (y !== 32'd4) $display("FAIL mid_rst_y: got %h want %h", y, 32'd4);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (y_q !== 32'd0) $display("FAIL mid_rst_y_q: got %h want %h", y_q, 32'd0);
    else pass_cnt++;
    total_cnt++;
    if (sel_err_q !== 1'b0) $display("FAIL mid_rst_sel_err_q: got %b want 0", sel_err_q);
    else pass_cnt++;
    total_cnt++;
    if (y !== 32'd4) $display("FAIL mid_rst_y_hold: got %h want %h", y, 32'd4);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (y_q !== 32'd4) $display("FAIL mid_post_y_q: got %h want %h", y_q, 32'd4);
    else pass_cnt++;
    total_cnt++;
    if (sel_err_q !== 1'b0) $display("FAIL mid_post_sel_err_q: got %b want 0", sel_err_q);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; a0 = 0; a1 = 0; a2 = 0; a3 = 0; s = 3'd0;
    #2;
    test_reset();
    test_sticky();
    test_sweep();
    test_illegal_high();
    test_hold_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
